// File: rtl/coin_button_conditioner.sv
// Front end for the vending-machine controller: synchronises and debounces the coin
// sensors and product buttons, then serialises accepted coins and returns the excess.
module coin_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] coin_raw,
  input  logic [2:0] btn_raw,
  input  logic       coin_en,
  output logic [2:0] money_in,
  output logic [2:0] btn_level,
  output logic [2:0] btn_pulse,
  output logic       coin_reject
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Lines 2:0 are the coin sensors, lines 5:3 the buttons.
  logic [5:0]       raw;
  logic [5:0]       s1;
  logic [5:0]       s2;
  logic [5:0]       deb;
  logic [5:0]       deb_d;
  logic [5:0]       rise;
  logic [CNT_W-1:0] cnt [6];

  logic [2:0] pending;
  logic [2:0] pending_next;
  logic [2:0] coin_rise;
  logic [2:0] cand;
  logic [2:0] sel;
  logic [2:0] reject_mask;
  logic [1:0] rej_new;
  logic [1:0] rej_cnt;
  logic [1:0] rej_cnt_next;
  logic [2:0] rej_total;
  logic [2:0] rej_left;

  assign raw       = {btn_raw, coin_raw};
  assign rise      = deb & ~deb_d;
  assign coin_rise = rise[2:0];
  assign btn_level = deb[5:3];

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= '0;
      s2    <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 6; i++) cnt[i] <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      deb_d <= deb;
      for (int i = 0; i < 6; i++) begin
        if (s2[i] != deb[i]) begin
          if (cnt[i] == CNT_LAST) begin
            deb[i] <= ~deb[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // A fresh coin on a line still holding a queued coin is accepted only if the queued
  // one leaves this cycle; otherwise it goes back down the chute.
  always_comb begin
    cand         = coin_en ? (pending | coin_rise) : 3'b000;
    sel          = 3'b000;
    if (cand[0])      sel = 3'b001;
    else if (cand[1]) sel = 3'b010;
    else if (cand[2]) sel = 3'b100;
    pending_next = pending;
    reject_mask  = coin_rise;
    if (coin_en) begin
      pending_next = ((pending | coin_rise) & ~sel) | (pending & coin_rise & sel);
      reject_mask  = coin_rise & pending & ~sel;
    end
    rej_new      = {1'b0, reject_mask[0]} + {1'b0, reject_mask[1]} + {1'b0, reject_mask[2]};
    rej_total    = {1'b0, rej_cnt} + {1'b0, rej_new};
    rej_left     = (rej_total == 3'd0) ? 3'd0 : rej_total - 3'd1;
    rej_cnt_next = (rej_left > 3'd3) ? 2'd3 : rej_left[1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending     <= '0;
      money_in    <= '0;
      btn_pulse   <= '0;
      coin_reject <= 1'b0;
      rej_cnt     <= '0;
    end else begin
      pending     <= pending_next;
      money_in    <= sel;
      btn_pulse   <= rise[5:3];
      coin_reject <= (rej_total != 3'd0);
      rej_cnt     <= rej_cnt_next;
    end
  end

endmodule

// File: tb/tb_coin_button_conditioner.sv
// Directed bench for coin_button_conditioner with a short debounce window (4 cycles),
// checking every output on every cycle of each scenario.
module tb_coin_button_conditioner;

  logic       clk;
  logic       reset;
  logic [2:0] coin_raw;
  logic [2:0] btn_raw;
  logic       coin_en;
  logic [2:0] money_in;
  logic [2:0] btn_level;
  logic [2:0] btn_pulse;
  logic       coin_reject;

  int total;
  int bad;

  coin_button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .coin_raw   (coin_raw),
    .btn_raw    (btn_raw),
    .coin_en    (coin_en),
    .money_in   (money_in),
    .btn_level  (btn_level),
    .btn_pulse  (btn_pulse),
    .coin_reject(coin_reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [2:0] coin, input logic [2:0] btn, input logic en);
    coin_raw = coin;
    btn_raw  = btn;
    coin_en  = en;
  endtask

  // Inputs are changed and outputs sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [2:0] em, input logic er,
                             input logic [2:0] el, input logic [2:0] ep);
    logic [9:0] obs;
    logic [9:0] exp;
    obs = {money_in, coin_reject, btn_level, btn_pulse};
    exp = {em, er, el, ep};
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s t=%0t observed money/rej/lvl/pulse=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  task automatic quietCycles(input int n, input string tag, input logic [2:0] el);
    for (int k = 0; k < n; k++) begin
      tick();
      checkOutput(tag, 3'b000, 1'b0, el, 3'b000);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    applyStimulus(3'b000, 3'b000, 1'b0);
    tick();
    tick();
    checkOutput("reset_state", 3'b000, 1'b0, 3'b000, 3'b000);
    reset = 1'b0;
    quietCycles(3, "post_reset", 3'b000);

    // Single 2 zl coin held 10 cycles: one pulse 7 edges after the first high sample.
    applyStimulus(3'b010, 3'b000, 1'b1);
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 10) applyStimulus(3'b000, 3'b000, 1'b1);
      checkOutput("coin2_single", (k == 7) ? 3'b010 : 3'b000, 1'b0, 3'b000, 3'b000);
    end

    // Bouncing 1 zl sensor: no pulse until the line has been stable long enough.
    for (int b = 0; b < 4; b++) begin
      applyStimulus((b % 2 == 0) ? 3'b001 : 3'b000, 3'b000, 1'b1);
      quietCycles(2, "coin1_bounce", 3'b000);
    end
    applyStimulus(3'b001, 3'b000, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      checkOutput("coin1_stable", (k == 7) ? 3'b001 : 3'b000, 1'b0, 3'b000, 3'b000);
    end
    applyStimulus(3'b000, 3'b000, 1'b1);
    quietCycles(10, "coin1_release", 3'b000);

    // 1 zl and 5 zl together: serialised by priority, nothing rejected.
    applyStimulus(3'b101, 3'b000, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      tick();
      checkOutput("coin_1_5_pair", (k == 7) ? 3'b001 : (k == 8) ? 3'b100 : 3'b000,
                  1'b0, 3'b000, 3'b000);
    end
    applyStimulus(3'b000, 3'b000, 1'b1);
    quietCycles(10, "pair_release", 3'b000);

    // Coin while not accepting: one reject pulse, not queued.
    applyStimulus(3'b100, 3'b000, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 8) applyStimulus(3'b000, 3'b000, 1'b0);
      checkOutput("coin5_reject", 3'b000, (k == 7), 3'b000, 3'b000);
    end
    applyStimulus(3'b000, 3'b000, 1'b1);
    quietCycles(4, "reject_not_pending", 3'b000);

    // Three coins while not accepting: three reject pulses on consecutive cycles.
    applyStimulus(3'b111, 3'b000, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      checkOutput("triple_reject", 3'b000, (k >= 7 && k <= 9), 3'b000, 3'b000);
    end
    applyStimulus(3'b000, 3'b000, 1'b0);
    quietCycles(10, "triple_release", 3'b000);

    // Three coins accepted: 1 zl goes out at once, the rest wait while coin_en is low.
    applyStimulus(3'b111, 3'b000, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      tick();
      checkOutput("queue_fill", (k == 7) ? 3'b001 : 3'b000, 1'b0, 3'b000, 3'b000);
    end
    applyStimulus(3'b000, 3'b000, 1'b0);
    quietCycles(5, "queue_hold", 3'b000);
    applyStimulus(3'b000, 3'b000, 1'b1);
    tick();
    checkOutput("queue_drain_2zl", 3'b010, 1'b0, 3'b000, 3'b000);
    // Reset mid-dispatch discards the queued 5 zl coin silently.
    reset = 1'b1;
    tick();
    checkOutput("reset_mid_dispatch", 3'b000, 1'b0, 3'b000, 3'b000);
    reset = 1'b0;
    quietCycles(10, "after_reset_quiet", 3'b000);

    // Coffee and hot chocolate pressed together, then released.
    applyStimulus(3'b000, 3'b110, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      checkOutput("btn_press", 3'b000, 1'b0, (k >= 6) ? 3'b110 : 3'b000,
                  (k == 7) ? 3'b110 : 3'b000);
    end
    applyStimulus(3'b000, 3'b000, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      checkOutput("btn_release", 3'b000, 1'b0, (k >= 6) ? 3'b000 : 3'b110, 3'b000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
